// File: rtl/booth_pkg.sv
// Shared types and defaults for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } booth_state_t;

endpackage

// File: rtl/booth_ctrl.sv
// Booth multiplier controller: sequences operand loads, WIDTH Booth iterations and result hold.
// With BOOTH_BUSY_EN defined, also drives a busy flag for the load and run phases.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_M | multiplicand on data_in; clear A, Q-1, reload counter
// LOAD_Q | multiplier on data_in
// RUN    | one Booth add/sub + arithmetic shift per cycle
// DONE   | product valid, held until the next start
module booth_ctrl
  import booth_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  input  logic cnt_zero,
  output logic ld_m,
  output logic ld_q,
  output logic clr_a,
  output logic clr_ff,
  output logic ld_cnt,
  output logic decr,
  output logic run,
  output logic op_add,
  output logic op_sub,
`ifdef BOOTH_BUSY_EN
  output logic busy,
`endif
  output logic done
);

  booth_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD_M;
      LOAD_M:  state_d = LOAD_Q;
      LOAD_Q:  state_d = RUN;
      RUN:     if (cnt_zero) state_d = DONE;
      DONE:    if (start) state_d = LOAD_M;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_m   = (state_q == LOAD_M);
    clr_a  = (state_q == LOAD_M);
    clr_ff = (state_q == LOAD_M);
    ld_cnt = (state_q == LOAD_M);
    ld_q   = (state_q == LOAD_Q);
    run    = (state_q == RUN);
    decr   = (state_q == RUN);
    // Booth pair {Q0,Q-1}: 10 subtracts M, 01 adds M
    op_sub = run && q0 && !qm1;
    op_add = run && !q0 && qm1;
    done   = (state_q == DONE);
`ifdef BOOTH_BUSY_EN
    busy   = (state_q == LOAD_M) || (state_q == LOAD_Q) || (state_q == RUN);
`endif
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: datapath (A, Q, M, Q-1, counter) around booth_ctrl.
// Optional BOOTH_BUSY_EN adds a busy output high during LOAD_M, LOAD_Q and RUN.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  output logic [2*WIDTH-1:0] product,
`ifdef BOOTH_BUSY_EN
  output logic               busy,
`endif
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  // A carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow
  logic [WIDTH:0]   a_q, a_d, a_sum, m_ext;
  logic [WIDTH-1:0] q_q, q_d, m_q, m_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_dec;
  logic             cnt_zero;
  logic             ld_m, ld_q, clr_a, clr_ff, ld_cnt, decr, run, op_add, op_sub;

  booth_ctrl u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .q0       (q_q[0]),
    .qm1      (qm1_q),
    .cnt_zero (cnt_zero),
    .ld_m     (ld_m),
    .ld_q     (ld_q),
    .clr_a    (clr_a),
    .clr_ff   (clr_ff),
    .ld_cnt   (ld_cnt),
    .decr     (decr),
    .run      (run),
    .op_add   (op_add),
    .op_sub   (op_sub),
`ifdef BOOTH_BUSY_EN
    .busy     (busy),
`endif
    .done     (done)
  );

  assign cnt_dec  = cnt_q - CW'(1);
  assign cnt_zero = (cnt_dec == '0);
  assign m_ext    = {m_q[WIDTH-1], m_q};
  assign product  = {a_q[WIDTH-1:0], q_q};

  always_comb begin
    a_sum = a_q;
    if (op_sub)      a_sum = a_q - m_ext;
    else if (op_add) a_sum = a_q + m_ext;
  end

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    m_d   = m_q;
    qm1_d = qm1_q;
    cnt_d = cnt_q;
    if (ld_m)   m_d   = data_in;
    if (clr_a)  a_d   = '0;
    if (clr_ff) qm1_d = 1'b0;
    if (ld_cnt) cnt_d = CW'(WIDTH);
    if (ld_q)   q_d   = data_in;
    // arithmetic right shift of {A,Q,Q-1} after the add/sub
    if (run) begin
      a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
      q_d   = {a_sum[0], q_q[WIDTH-1:1]};
      qm1_d = q_q[0];
    end
    if (decr)   cnt_d = cnt_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      q_q   <= '0;
      m_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      m_q   <= m_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier: reset, products, done timing, restart, abort, busy (BOOTH_BUSY_EN).
module tb_booth_multiplier;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   data_in;
  logic [2*W-1:0] product;
  logic           done;
`ifdef BOOTH_BUSY_EN
  logic           busy;
`endif

  int n_pass;
  int n_total;

  booth_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .product (product),
`ifdef BOOTH_BUSY_EN
    .busy    (busy),
`endif
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 time unit after edge E+2+W.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp_p, input int pulse_at, input string tag);
    bit early;
    start = 1'b1;
    data_in = '0;
    @(posedge clk); #1;
    start = 1'b0;
    data_in = a;
    n_total++;
    if (done !== 1'b0) $display("FAIL %s done_clr: got %b expected 0", tag, done);
    else n_pass++;
    @(posedge clk); #1;
    data_in = b;
`ifdef BOOTH_BUSY_EN
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_e1: got %b expected 1", tag, busy);
    else n_pass++;
`endif
    @(posedge clk); #1;
    data_in = '0;
    early = 1'b0;
    for (int k = 3; k <= W + 2; k++) begin
      start = (k == pulse_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (k < W + 2 && done !== 1'b0) early = 1'b1;
`ifdef BOOTH_BUSY_EN
      if (k == W + 1) begin
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s busy_e17: got %b expected 1", tag, busy);
        else n_pass++;
      end
`endif
    end
    n_total++;
    if (early !== 1'b0) $display("FAIL %s done_early: got %b expected 0", tag, early);
    else n_pass++;
    n_total++;
    if (done !== 1'b1) $display("FAIL %s done_e18: got %b expected 1", tag, done);
    else n_pass++;
    n_total++;
    if (product !== exp_p) $display("FAIL %s product: got %h expected %h", tag, product, exp_p);
    else n_pass++;
`ifdef BOOTH_BUSY_EN
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s busy_e18: got %b expected 0", tag, busy);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (product !== '0) $display("FAIL reset product: got %h expected 0", product);
    else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL reset done: got %b expected 0", done);
    else n_pass++;
`ifdef BOOTH_BUSY_EN
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op(16'd3,      16'hFFFC, 32'hFFFF_FFF4, 0, "3x-4");
    do_op(16'd7,      16'd5,    32'd35,        0, "7x5");
    do_op(16'hFFFF,   16'hFFFF, 32'd1,         0, "-1x-1");
    do_op(16'd0,      16'd12345, 32'd0,        0, "0x12345");
    do_op(16'h8000,   16'h8000, 32'h4000_0000, 0, "min_x_min");
    do_op(16'h7FFF,   16'h8000, 32'hC000_8000, 0, "max_x_min");
  endtask

  task automatic test_hold();
    logic [2*W-1:0] snap;
    snap = product;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (done !== 1'b1) $display("FAIL hold done: got %b expected 1", done);
    else n_pass++;
    n_total++;
    if (product !== 32'hC000_8000) $display("FAIL hold product: got %h expected %h", product, snap);
    else n_pass++;
  endtask

  task automatic test_restart_ignored();
    do_op(16'd100, 16'hFF9C, 32'hFFFF_D8F0, 8, "restart_run");
    do_op(16'd12,  16'd11,   32'd132,       W + 2, "restart_last");
  endtask

  task automatic test_back_to_back();
    do_op(16'h1234, 16'd2,   32'h0000_2468, 0, "b2b_1");
    do_op(16'hFFF6, 16'd10,  32'hFFFF_FF9C, 0, "b2b_2");
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_in = 16'd7;
    @(posedge clk); #1;
    data_in = 16'd5;
    @(posedge clk); #1;
    data_in = '0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (product !== '0) $display("FAIL abort product: got %h expected 0", product);
    else n_pass++;
    n_total++;
    if (done !== 1'b0) $display("FAIL abort done: got %b expected 0", done);
    else n_pass++;
`ifdef BOOTH_BUSY_EN
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort busy: got %b expected 0", busy);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (done !== 1'b0) $display("FAIL abort idle_done: got %b expected 0", done);
    else n_pass++;
    do_op(16'hFFFD, 16'd7, 32'hFFFF_FFEB, 0, "after_abort");
  endtask

  task automatic test_random();
    logic signed [W-1:0]   ra, rb;
    logic signed [2*W-1:0] e;
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      e  = ra * rb;
      do_op(ra, rb, e, 0, "random");
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_hold();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
